// File: rtl/parse_board_pkg.sv
// game_pkg: definitions shared by the game sub-blocks.
//   - default board geometry (ROWS_DEF x COLS_DEF)
//   - character constants of the board text format
//   - parse FSM state enum and byte classification enum
//   - classify_char(): maps a received byte to its cell class
package game_pkg;

  localparam int ROWS_DEF = 3;
  localparam int COLS_DEF = 3;

  localparam logic [7:0] CH_A       = 8'h6F;
  localparam logic [7:0] CH_A_UP    = 8'h4F;
  localparam logic [7:0] CH_B       = 8'h78;
  localparam logic [7:0] CH_B_UP    = 8'h58;
  localparam logic [7:0] CH_EMPTY   = 8'h2E;
  localparam logic [7:0] CH_DASH    = 8'h2D;
  localparam logic [7:0] CH_SPACE   = 8'h20;
  localparam logic [7:0] CH_BAR     = 8'h7C;
  localparam logic [7:0] CH_LF      = 8'h0A;
  localparam logic [7:0] CH_CR      = 8'h0D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_SKIP,
    ST_DONE_OK,
    ST_DONE_ERR
  } parse_state_t;

  typedef enum logic [2:0] {
    CELL_A,
    CELL_B,
    CELL_EMPTY,
    IGNORE,
    TERM,
    BAD
  } cell_class_t;

  // Upper and lower case piece letters are accepted so that hand-typed
  // positions from a terminal work regardless of caps lock.
  function automatic cell_class_t classify_char(input logic [7:0] ch);
    cell_class_t cls;
    case (ch)
      CH_A, CH_A_UP:           cls = CELL_A;
      CH_B, CH_B_UP:           cls = CELL_B;
      CH_EMPTY, CH_DASH:       cls = CELL_EMPTY;
      CH_SPACE, CH_BAR, CH_CR: cls = IGNORE;
      CH_LF:                   cls = TERM;
      default:                 cls = BAD;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/parse_board_if.sv
// parse_board_if: host-side handshake and UART byte bus of parse_board.
//   req         host -> parser, one-cycle start request
//   ready       parser -> host, idle and able to accept req
//   uart_rd     host -> parser, one-cycle strobe, uart_q is a new byte
//   uart_q      host -> parser, received byte
//   board_a_out parser -> host, decoded 'o' cells (bit r*COLS+c)
//   board_b_out parser -> host, decoded 'x' cells
//   valid       parser -> host, one-cycle pulse, parse finished
//   error_flag  parser -> host, qualified by valid, parse failed
// Modports: master = host / game logic side, slave = parser.
interface parse_board_if #(
  parameter int ROWS = 3,
  parameter int COLS = 3
);

  logic                 req;
  logic                 ready;
  logic                 uart_rd;
  logic [7:0]           uart_q;
  logic [ROWS*COLS-1:0] board_a_out;
  logic [ROWS*COLS-1:0] board_b_out;
  logic                 valid;
  logic                 error_flag;

  modport master (
    output req,
    output uart_rd,
    output uart_q,
    input  ready,
    input  board_a_out,
    input  board_b_out,
    input  valid,
    input  error_flag
  );

  modport slave (
    input  req,
    input  uart_rd,
    input  uart_q,
    output ready,
    output board_a_out,
    output board_b_out,
    output valid,
    output error_flag
  );

endinterface

// File: rtl/parse_board_classify.sv
// board_char_classify: purely combinational byte -> cell class decoder.
//   ch  input  8  received byte
//   cls output    cell_class_t (CELL_A, CELL_B, CELL_EMPTY, IGNORE, TERM, BAD)
// Kept as its own block so the keyboard decoder can reuse it.
module board_char_classify
  import game_pkg::*;
(
  input  logic [7:0]  ch,
  output cell_class_t cls
);

  always_comb begin
    cls = classify_char(ch);
  end

endmodule

// File: rtl/parse_board.sv
// parse_board: decodes one board text line received over UART into
// board_a (the 'o' cells) and board_b (the 'x' cells). Inverse of
// print_board; lets a host load an arbitrary position.
//   clk    input  system clock
//   reset  input  asynchronous active-high reset
//   bus    parse_board_if.slave: req/ready start handshake, uart_rd/uart_q
//          byte strobe, board_a_out/board_b_out/valid/error_flag result
// Parameters: ROWS, COLS board geometry; SYS_CLK_FREQ documents the clock
// the timeout is scaled against; TIMEOUT_CYCLES idle cycles between bytes
// before aborting (0 disables the timeout).
module parse_board
  import game_pkg::*;
#(
  parameter int ROWS           = ROWS_DEF,
  parameter int COLS           = COLS_DEF,
  parameter int SYS_CLK_FREQ   = 100000000,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input logic          clk,
  input logic          reset,
  parse_board_if.slave bus
);

  localparam int CELLS = ROWS * COLS;
  localparam int CNT_W = $clog2(CELLS + 1);
  localparam int TO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0] CELLS_C  = CNT_W'(CELLS);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic             TO_EN    = (TIMEOUT_CYCLES > 0);

  if (SYS_CLK_FREQ <= 0) begin : g_freq_check
    $error("parse_board: SYS_CLK_FREQ must be positive");
  end

  parse_state_t     state;
  parse_state_t     next_state;
  cell_class_t      cls;
  logic [CNT_W-1:0] cell_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [CELLS-1:0] shadow_a;
  logic [CELLS-1:0] shadow_b;
  logic [CELLS-1:0] board_a_q;
  logic [CELLS-1:0] board_b_q;
  logic             err_q;
  logic             board_full;
  logic             is_cell;
  logic             to_expire;
  logic             ready_c;
  logic             valid_c;

  board_char_classify u_classify (
    .ch  (bus.uart_q),
    .cls (cls)
  );

  assign board_full = (cell_cnt == CELLS_C);
  assign is_cell    = (cls == CELL_A) || (cls == CELL_B) || (cls == CELL_EMPTY);

  // The timeout fires on the idle cycle that would bring the counter to
  // TIMEOUT_CYCLES, so exactly TIMEOUT_CYCLES idle cycles abort the parse.
  assign to_expire  = TO_EN && !bus.uart_rd && ((to_cnt + TO_W'(1)) == TO_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (bus.req) begin
          next_state = ST_RECV;
        end
      end
      ST_RECV: begin
        if (bus.uart_rd) begin
          case (cls)
            CELL_A, CELL_B, CELL_EMPTY: begin
              if (board_full) begin
                next_state = ST_SKIP;
              end
            end
            TERM:    next_state = board_full ? ST_DONE_OK : ST_DONE_ERR;
            BAD:     next_state = ST_SKIP;
            default: next_state = ST_RECV;
          endcase
        end else if (to_expire) begin
          next_state = ST_DONE_ERR;
        end
      end
      ST_SKIP: begin
        if (bus.uart_rd) begin
          if (cls == TERM) begin
            next_state = ST_DONE_ERR;
          end
        end else if (to_expire) begin
          next_state = ST_DONE_ERR;
        end
      end
      ST_DONE_OK:  next_state = ST_IDLE;
      ST_DONE_ERR: next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_c = 1'b0;
    valid_c = 1'b0;
    case (state)
      ST_IDLE:     ready_c = 1'b1;
      ST_DONE_OK:  valid_c = 1'b1;
      ST_DONE_ERR: valid_c = 1'b1;
      default: begin
        ready_c = 1'b0;
        valid_c = 1'b0;
      end
    endcase
  end

  // Shadow boards collect cells while receiving; the published outputs
  // only change when a parse completes. A byte arriving with req is not
  // looked at, since the parser is still idle in that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_a <= '0;
      shadow_b <= '0;
      cell_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            shadow_a <= '0;
            shadow_b <= '0;
            cell_cnt <= '0;
            to_cnt   <= '0;
          end
        end
        ST_RECV, ST_SKIP: begin
          if (bus.uart_rd) begin
            to_cnt <= '0;
          end else if (TO_EN) begin
            to_cnt <= to_cnt + TO_W'(1);
          end
          if (state == ST_RECV && bus.uart_rd && is_cell && !board_full) begin
            if (cls == CELL_A) begin
              shadow_a <= shadow_a | (CELLS'(1) << cell_cnt);
            end
            if (cls == CELL_B) begin
              shadow_b <= shadow_b | (CELLS'(1) << cell_cnt);
            end
            cell_cnt <= cell_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Results are loaded on the edge that enters a DONE state so they are
  // already stable while valid is high, and held until the next DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      board_a_q <= '0;
      board_b_q <= '0;
      err_q     <= 1'b0;
    end else if (next_state == ST_DONE_OK) begin
      board_a_q <= shadow_a;
      board_b_q <= shadow_b;
      err_q     <= 1'b0;
    end else if (next_state == ST_DONE_ERR) begin
      board_a_q <= '0;
      board_b_q <= '0;
      err_q     <= 1'b1;
    end
  end

  assign bus.ready       = ready_c;
  assign bus.valid       = valid_c;
  assign bus.error_flag  = err_q;
  assign bus.board_a_out = board_a_q;
  assign bus.board_b_out = board_b_q;

endmodule
